// File: rtl/i2c_write_master_if.sv
// rtl/i2c_write_master_if.sv - request/status and SCL signals of the I2C write engine
// SDA is open-drain and stays a plain inout port on the engine.
interface i2c_write_master_if;
   logic        go;
   logic [23:0] data;
   logic        i2c_sclk;
   logic        done;
   logic        ack;

   modport master (
      input  go,
      input  data,
      output i2c_sclk,
      output done,
      output ack
   );

   modport slave (
      output go,
      output data,
      input  i2c_sclk,
      input  done,
      input  ack
   );
endinterface

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - bit-level I2C engine for one 3-byte write (START, 3 bytes, STOP)
// Every bus slot is four quarters of Q system clocks; SCL/SDA are decoded from state and quarter.
module i2c_write_master #(
   parameter int REF_CLK = 50_000_000,
   parameter int I2C_CLK = 100_000
) (
   input  logic                  clk_50m,
   input  logic                  rst,
   i2c_write_master_if.master    bus,
   inout  wire                   i2c_sdat
);
   localparam int Q  = REF_CLK / (I2C_CLK * 4);
   localparam int QW = (Q > 1) ? $clog2(Q) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_ACKS,
      S_STOP,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    quarter_q, quarter_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [1:0]    bytecnt_q, bytecnt_d;
   logic [23:0]   shift_q, shift_d;
   logic          ack_q, ack_d;

   logic          qend;
   logic          slot_end;
   logic          sclk;
   logic          sda_low;

   assign qend     = (qcnt_q == QW'(Q - 1));
   assign slot_end = qend && (quarter_q == 2'd3);

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q   <= S_IDLE;
         qcnt_q    <= '0;
         quarter_q <= '0;
         bitcnt_q  <= '0;
         bytecnt_q <= '0;
         shift_q   <= '0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         quarter_q <= quarter_d;
         bitcnt_q  <= bitcnt_d;
         bytecnt_q <= bytecnt_d;
         shift_q   <= shift_d;
         ack_q     <= ack_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      quarter_d = quarter_q;
      bitcnt_d  = bitcnt_q;
      bytecnt_d = bytecnt_q;
      shift_d   = shift_q;
      ack_d     = ack_q;

      if (state_q inside {S_START, S_BIT, S_ACKS, S_STOP}) begin
         qcnt_d = qend ? '0 : qcnt_q + 1'b1;
         if (qend) begin
            quarter_d = quarter_q + 2'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            qcnt_d    = '0;
            quarter_d = '0;
            bitcnt_d  = '0;
            bytecnt_d = '0;
            if (bus.go) begin
               shift_d = bus.data;
               ack_d   = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (slot_end) begin
               state_d = S_BIT;
            end
         end
         S_BIT: begin
            if (slot_end) begin
               shift_d  = {shift_q[22:0], 1'b0};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = S_ACKS;
               end
            end
         end
         S_ACKS: begin
            // Released SDA reads high through the pull-up, so a missing slave is a NACK.
            if (qend && (quarter_q == 2'd1) && (i2c_sdat != 1'b0)) begin
               ack_d = 1'b1;
            end
            if (slot_end) begin
               if (ack_q || (bytecnt_q == 2'd2)) begin
                  state_d = S_STOP;
               end else begin
                  bytecnt_d = bytecnt_q + 2'd1;
                  state_d   = S_BIT;
               end
            end
         end
         S_STOP: begin
            if (slot_end) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!bus.go) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sclk    = 1'b1;
      sda_low = 1'b0;
      case (state_q)
         S_START: begin
            sclk    = (quarter_q != 2'd3);
            sda_low = (quarter_q >= 2'd2);
         end
         S_BIT: begin
            sclk    = (quarter_q == 2'd1) || (quarter_q == 2'd2);
            sda_low = ~shift_q[23];
         end
         S_ACKS: begin
            sclk    = (quarter_q == 2'd1) || (quarter_q == 2'd2);
         end
         S_STOP: begin
            sclk    = (quarter_q != 2'd0);
            sda_low = (quarter_q <= 2'd1);
         end
         default: begin
            sclk    = 1'b1;
            sda_low = 1'b0;
         end
      endcase
   end

   assign bus.i2c_sclk = sclk;
   assign bus.done     = (state_q == S_DONE);
   assign bus.ack      = ack_q;
   assign i2c_sdat     = sda_low ? 1'b0 : 1'bz;
endmodule
